// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared state codes and status-word layout for the button reader
package btn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DB_PRESS = 3'd1,
    ST_PRESSED  = 3'd2,
    ST_HELD     = 3'd3,
    ST_DB_REL   = 3'd4
  } btn_state_e;

  localparam int STATE_W        = 3;
  localparam int STAT_LEVEL     = 0;
  localparam int STAT_LONG      = 1;
  localparam int STAT_STATE_LSB = 2;
  localparam int STAT_CNT_LSB   = 8;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous level
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/gpio_button_reader.sv
// rtl/gpio_button_reader.sv - debounced push-button reader with press/release/long events
// and a packed status word for the PS GPIO input channel.
module gpio_button_reader
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned LONG_CYCLES     = 25_000_000,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_in,
  input  logic             clr_i,
  output logic             level_o,
  output logic             press_o,
  output logic             release_o,
  output logic             long_o,
  output logic             long_flag_o,
  output logic [CNT_W-1:0] press_cnt_o,
  output logic [31:0]      status_o
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned LONG_W = $clog2(LONG_CYCLES);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

  logic btn_sync;
  logic clr_sync;
  logic btn_s;
  logic clr_pulse;

  btn_state_e        state_q, state_d;
  logic [DB_W-1:0]   db_t_q, db_t_d;
  logic [LONG_W-1:0] hold_t_q, hold_t_d;
  logic              long_fired_q, long_fired_d;
  logic              clr_prev_q, clr_prev_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;
  logic              long_flag_q, long_flag_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // The pin idles at its inactive level, so reset the synchronizer there.
  sync_2ff #(.RESET_VAL(ACTIVE_LOW ? 1'b1 : 1'b0)) u_btn_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (btn_in),
    .q_o   (btn_sync)
  );

  sync_2ff #(.RESET_VAL(1'b0)) u_clr_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (clr_i),
    .q_o   (clr_sync)
  );

  assign btn_s      = ACTIVE_LOW ? ~btn_sync : btn_sync;
  assign clr_prev_d = clr_sync;
  assign clr_pulse  = clr_sync & ~clr_prev_q;

  always_comb begin
    state_d      = state_q;
    db_t_d       = db_t_q;
    hold_t_d     = hold_t_q;
    long_fired_d = long_fired_q;
    level_d      = level_q;
    press_d      = 1'b0;
    release_d    = 1'b0;
    long_d       = 1'b0;
    cnt_d        = cnt_q;
    long_flag_d  = long_flag_q;

    // Clear is applied first so a coincident press or long event overrides it.
    if (clr_pulse) begin
      cnt_d       = '0;
      long_flag_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (btn_s) begin
          state_d = ST_DB_PRESS;
          db_t_d  = '0;
        end
      end
      ST_DB_PRESS: begin
        if (!btn_s) begin
          state_d = ST_IDLE;
        end else if (db_t_q == DB_LAST) begin
          state_d      = ST_PRESSED;
          press_d      = 1'b1;
          level_d      = 1'b1;
          cnt_d        = cnt_d + CNT_W'(1);
          hold_t_d     = '0;
          long_fired_d = 1'b0;
        end else begin
          db_t_d = db_t_q + DB_W'(1);
        end
      end
      ST_PRESSED: begin
        if (!btn_s) begin
          state_d = ST_DB_REL;
          db_t_d  = '0;
        end else if (hold_t_q == LONG_LAST) begin
          state_d      = ST_HELD;
          long_d       = 1'b1;
          long_flag_d  = 1'b1;
          long_fired_d = 1'b1;
        end else begin
          hold_t_d = hold_t_q + LONG_W'(1);
        end
      end
      ST_HELD: begin
        if (!btn_s) begin
          state_d = ST_DB_REL;
          db_t_d  = '0;
        end
      end
      ST_DB_REL: begin
        // A rejected release resumes where the hold left off; hold_t stays frozen.
        if (btn_s) begin
          state_d = long_fired_q ? ST_HELD : ST_PRESSED;
        end else if (db_t_q == DB_LAST) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          db_t_d = db_t_q + DB_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      db_t_q       <= '0;
      hold_t_q     <= '0;
      long_fired_q <= 1'b0;
      clr_prev_q   <= 1'b0;
      level_q      <= 1'b0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      long_q       <= 1'b0;
      long_flag_q  <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      db_t_q       <= db_t_d;
      hold_t_q     <= hold_t_d;
      long_fired_q <= long_fired_d;
      clr_prev_q   <= clr_prev_d;
      level_q      <= level_d;
      press_q      <= press_d;
      release_q    <= release_d;
      long_q       <= long_d;
      long_flag_q  <= long_flag_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    status_o                                  = '0;
    status_o[STAT_LEVEL]                      = level_q;
    status_o[STAT_LONG]                       = long_flag_q;
    status_o[STAT_STATE_LSB +: STATE_W]       = state_q;
    status_o[STAT_CNT_LSB +: CNT_W]           = cnt_q;
  end

  assign level_o     = level_q;
  assign press_o     = press_q;
  assign release_o   = release_q;
  assign long_o      = long_q;
  assign long_flag_o = long_flag_q;
  assign press_cnt_o = cnt_q;

endmodule

// File: tb/tb_gpio_button_reader.sv
// tb/tb_gpio_button_reader.sv - scoreboard bench for the debounced button reader
module tb_gpio_button_reader;

  localparam int DB = 4;
  localparam int LG = 20;
  localparam int CW = 8;
  localparam int LAT = DB + 3;

  localparam int K_PRESS = 1;
  localparam int K_REL   = 2;
  localparam int K_LONG  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          btn_in = 1'b1;
  logic          clr_i = 1'b0;
  logic          level_o, press_o, release_o, long_o, long_flag_o;
  logic [CW-1:0] press_cnt_o;
  logic [31:0]   status_o;

  gpio_button_reader #(
    .DEBOUNCE_CYCLES (DB),
    .LONG_CYCLES     (LG),
    .ACTIVE_LOW      (1'b1),
    .CNT_W           (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_in      (btn_in),
    .clr_i       (clr_i),
    .level_o     (level_o),
    .press_o     (press_o),
    .release_o   (release_o),
    .long_o      (long_o),
    .long_flag_o (long_flag_o),
    .press_cnt_o (press_cnt_o),
    .status_o    (status_o)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;
    int unsigned at;
    logic [7:0]  cnt;
  } ev_t;

  ev_t        exp_q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] exp_cnt = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int kind, input int unsigned at, input logic [7:0] c);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    e.cnt  = c;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
      n_chk++;
      n_fail++;
      $display("FAIL missed_event: kind %0d expected at cycle %0d, still absent at cycle %0d",
               exp_q[0].kind, exp_q[0].at, cyc);
      void'(exp_q.pop_front());
    end
    if (rst_n && (press_o || release_o || long_o)) begin
      check("pulse_onehot", $countones({long_o, release_o, press_o}), 1);
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, required none",
                 {long_o, release_o, press_o}, cyc);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("event_kind", {29'd0, long_o, release_o, press_o}, e.kind);
        check("event_cycle", cyc, e.at);
        check("event_cnt", press_cnt_o, e.cnt);
        if (e.kind == K_LONG) check("long_flag_at_long", long_flag_o, 1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic btn_level);
    @(negedge clk);
    btn_in = btn_level;
    clr_i  = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("reset_status", status_o, 0);
    check("reset_outs", {level_o, press_o, release_o, long_o, long_flag_o, press_cnt_o}, 0);
    exp_q.delete();
    exp_cnt = 8'd0;
    tick(3);
    rst_n = 1'b1;
  endtask

  task automatic short_press();
    btn_in = 1'b0;
    exp_cnt++;
    push(K_PRESS, cyc + LAT, exp_cnt);
    tick(10);
    btn_in = 1'b1;
    push(K_REL, cyc + LAT, exp_cnt);
    tick(10);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;

    // Button held through reset release counts as a fresh press
    do_reset(1'b0);
    exp_cnt = 8'd1;
    push(K_PRESS, cyc + LAT, 8'd1);
    tick(10);
    check("t1_cnt", press_cnt_o, 1);
    check("t1_level", level_o, 1);
    btn_in = 1'b1;
    push(K_REL, cyc + LAT, 8'd1);
    tick(10);

    // Clean press, long hold, release
    do_reset(1'b1);
    tick(2);
    n = cyc;
    btn_in = 1'b0;
    push(K_PRESS, n + LAT, 8'd1);
    push(K_LONG, n + LAT + LG, 8'd1);
    tick(30);
    check("t2_level", level_o, 1);
    check("t2_state_held", status_o[4:2], 3);
    check("t2_long_flag", long_flag_o, 1);
    tick(10);
    btn_in = 1'b1;
    push(K_REL, cyc + LAT, 8'd1);
    tick(10);
    check("t2_status", status_o, 32'h0000_0102);

    // Bouncing input is rejected
    do_reset(1'b1);
    tick(2);
    for (int i = 0; i < 5; i++) begin
      btn_in = 1'b0;
      tick(3);
      btn_in = 1'b1;
      tick(2);
    end
    tick(10);
    check("t3_cnt", press_cnt_o, 0);
    check("t3_level", level_o, 0);
    check("t3_status", status_o, 0);

    // Short release glitch while pressed: hold resumes, three frozen edges
    do_reset(1'b1);
    tick(2);
    n = cyc;
    btn_in = 1'b0;
    push(K_PRESS, n + LAT, 8'd1);
    tick(12);
    btn_in = 1'b1;
    tick(2);
    btn_in = 1'b0;
    push(K_LONG, n + LAT + LG + 3, 8'd1);
    tick(5);
    check("t4_level", level_o, 1);
    check("t4_state_pressed", status_o[4:2], 2);
    tick(15);
    btn_in = 1'b1;
    push(K_REL, cyc + LAT, 8'd1);
    tick(10);

    // Clear behaviour, including collisions with press and long
    do_reset(1'b1);
    tick(2);
    for (int i = 0; i < 4; i++) short_press();
    n = cyc;
    btn_in = 1'b0;
    exp_cnt++;
    push(K_PRESS, n + LAT, exp_cnt);
    push(K_LONG, n + LAT + LG, exp_cnt);
    tick(30);
    btn_in = 1'b1;
    push(K_REL, cyc + LAT, exp_cnt);
    tick(10);
    check("t5_cnt_before", press_cnt_o, 5);
    check("t5_flag_before", long_flag_o, 1);
    clr_i = 1'b1;
    tick(3);
    check("t5_cnt_cleared", press_cnt_o, 0);
    check("t5_flag_cleared", long_flag_o, 0);
    tick(3);
    clr_i = 1'b0;
    tick(4);
    n = cyc;
    btn_in = 1'b0;
    exp_cnt = 8'd1;
    push(K_PRESS, n + LAT, 8'd1);
    tick(4);
    clr_i = 1'b1;
    tick(4);
    check("t5_press_wins", press_cnt_o, 1);
    clr_i = 1'b0;
    tick(16);
    clr_i = 1'b1;
    exp_cnt = 8'd0;
    push(K_LONG, n + LAT + LG, 8'd0);
    tick(4);
    check("t5_long_wins", long_flag_o, 1);
    check("t5_cnt_after_clr", press_cnt_o, 0);
    clr_i = 1'b0;
    tick(3);
    btn_in = 1'b1;
    push(K_REL, cyc + LAT, 8'd0);
    tick(10);

    // Counter wrap and asynchronous reset mid-debounce
    do_reset(1'b1);
    tick(2);
    for (int i = 0; i < 256; i++) short_press();
    check("t6_wrap", press_cnt_o, 0);
    short_press();
    btn_in = 1'b0;
    tick(4);
    check("t6_db_press_status", status_o, 32'h0000_0104);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_status", status_o, 0);
    check("t6_async_outs", {level_o, press_o, release_o, long_o, long_flag_o, press_cnt_o}, 0);
    exp_q.delete();
    btn_in = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(5);

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
